// File: rtl/sccb_master.sv
`timescale 1ns/1ps
// SCCB bus master: one register write (3-phase) or read (2-phase write, then 2-phase read)
// per command, serialised onto SIO_C/SIO_D with a one-cycle rdy grant handshake.
module sccb_master #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] DEV_ID  = 8'h42,
    parameter int                SCL_QTR = 125
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              sio_c,
    output logic              sio_d_out,
    output logic              sio_d_oe,
    input  logic              sio_d_in
);

    localparam int              QW    = (SCL_QTR > 1) ? $clog2(SCL_QTR) : 1;
    localparam int              BW    = $clog2(DATA_W + 1);
    localparam logic [QW-1:0]   QMAX  = QW'(SCL_QTR - 1);
    localparam logic [BW-1:0]   NINTH = BW'(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_BYTE, S_STOP, S_GAP} state_t;

    state_t            state_q, state_d;
    logic              gcnt_q, gcnt_d;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic              rd_q, rd_d;
    logic              ph2_q, ph2_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic              sc_q, sc_d;
    logic              sd_q, sd_d;
    logic              oe_q, oe_d;
    logic              tick;
    logic              cmd;
    logic              waiting;

    assign rdy       = rdy_q;
    assign rdata     = rdata_q;
    assign rdata_vld = vld_q;
    assign sio_c     = sc_q;
    assign sio_d_out = sd_q;
    assign sio_d_oe  = oe_q;

    // Bus levels {sio_c, sio_d_out, sio_d_oe} for a given sequencer position.
    function automatic logic [2:0] bus_drive(
        input state_t            st,
        input logic [1:0]        qtr,
        input logic [BW-1:0]     bc,
        input logic [1:0]        byc,
        input logic              ph2,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] txb;
        logic [DATA_W-1:0] sh;
        logic              c;
        logic              dout;
        logic              oe;
        txb  = (byc == 2'd0) ? (ph2 ? (DEV_ID | DATA_W'(1)) : DEV_ID) :
               (byc == 2'd1) ? a : d;
        sh   = txb << bc;
        c    = 1'b1;
        dout = 1'b1;
        oe   = 1'b1;
        case (st)
            S_START: begin
                c    = (qtr != 2'd3);
                dout = (qtr < 2'd2);
            end
            S_STOP: begin
                c    = (qtr != 2'd0);
                dout = (qtr >= 2'd2);
            end
            S_BYTE: begin
                c = (qtr == 2'd1) || (qtr == 2'd2);
                // read data byte: 8 released bits, then master drives NA high
                if (ph2 && byc == 2'd1) oe = (bc == NINTH);
                else if (bc == NINTH)   oe = 1'b0;
                else                    dout = sh[DATA_W-1];
            end
            default: ;
        endcase
        return {c, dout, oe};
    endfunction

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
        ph2_d   = ph2_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
        vld_d   = 1'b0;
        cmd     = wr_en | rd_en;
        waiting = (state_q == S_IDLE) || (state_q == S_GRANT);
        tick    = (qcnt_q == QMAX);
        qcnt_d  = (waiting || tick) ? '0 : qcnt_q + 1'b1;
        if (!waiting && tick) qtr_d = qtr_q + 2'd1;

        if (waiting && cmd) begin
            addr_d  = addr;
            wdata_d = wdata;
            rd_d    = rd_en & ~wr_en;
            ph2_d   = 1'b0;
            qtr_d   = 2'd0;
            bit_d   = '0;
            byte_d  = 2'd0;
            state_d = S_START;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_GRANT;
                    gcnt_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
                S_GRANT: begin
                    if (gcnt_q) state_d = S_IDLE;
                    else        gcnt_d  = 1'b1;
                end
                S_START: begin
                    if (tick && qtr_q == 2'd3) begin
                        state_d = S_BYTE;
                        bit_d   = '0;
                        byte_d  = 2'd0;
                    end
                end
                S_BYTE: begin
                    if (tick && qtr_q == 2'd1 && ph2_q && byte_q == 2'd1 && bit_q != NINTH)
                        rx_d = {rx_q[DATA_W-2:0], sio_d_in};
                    if (tick && qtr_q == 2'd3) begin
                        if (bit_q == NINTH) begin
                            bit_d = '0;
                            if (byte_q == (rd_q ? 2'd1 : 2'd2)) state_d = S_STOP;
                            else                                 byte_d  = byte_q + 2'd1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick && qtr_q == 2'd3) begin
                        if (rd_q && !ph2_q) begin
                            state_d = S_GAP;
                            ph2_d   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            if (rd_q) begin
                                rdata_d = rx_q;
                                vld_d   = 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick && qtr_q == 2'd3) begin
                        state_d = S_START;
                        byte_d  = 2'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        {sc_d, sd_d, oe_d} = bus_drive(state_d, qtr_d, bit_d, byte_d, ph2_d, addr_d, wdata_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gcnt_q  <= 1'b0;
            qcnt_q  <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= '0;
            byte_q  <= 2'd0;
            rd_q    <= 1'b0;
            ph2_q   <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            sc_q    <= 1'b1;
            sd_q    <= 1'b1;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            qcnt_q  <= qcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rd_q    <= rd_d;
            ph2_q   <= ph2_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            sc_q    <= sc_d;
            sd_q    <= sd_d;
            oe_q    <= oe_d;
        end
    end

    // Command payload and receive shifter carry no control meaning, so they skip reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rx_q    <= rx_d;
    end

endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB (two-wire, I2C-like) bus master between `ov7670_config` and the OV7670 sensor pins. It accepts one register write or register read per command from the config sequencer and serialises it onto SIO_C/SIO_D. It returns a one-cycle `rdy` grant pulse when it can take the next command, and delivers read data with a valid strobe. Sensor device ID is fixed by parameter: write 0x42, read 0x43.

## Interface
- `DATA_W`, 8, register address and data width.
- `DEV_ID`, 8'h42, 8-bit write slave address; read address is `DEV_ID|1`.
- `SCL_QTR`, 125, clk cycles per quarter SCL period; 125 at 50 MHz gives 100 kHz SCL.
- `clk` in 1: 50 MHz system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: one-cycle write command.
- `rd_en` in 1: one-cycle read command.
- `addr` in DATA_W: sub-address, sampled on the command cycle.
- `wdata` in DATA_W: write data, sampled on the `wr_en` cycle.
- `rdy` out 1: one-cycle grant pulse; a command is accepted 1–2 cycles after it.
- `rdata` out DATA_W: last read byte.
- `rdata_vld` out 1: one-cycle pulse when `rdata` is updated.
- `sio_c` out 1: SCCB clock, always driven.
- `sio_d_out` out 1: SIO_D drive value.
- `sio_d_oe` out 1: SIO_D output enable; 0 = released, pulled up externally.
- `sio_d_in` in 1: SIO_D pin readback.

## Operation
- **Reset values:** `rdy`=0, `rdata`=0, `rdata_vld`=0, `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1. State=IDLE and all counters 0.
- **Clock enable:** a quarter tick is generated every `SCL_QTR` clk cycles. The qtr counter counts 0..SCL_QTR-1 and wraps, and runs only outside IDLE/GRANT.
- **Bit slot (4 quarters):**
  - q0: SCL low; SDA changes.
  - q1: SCL rises.
  - q2: SCL high; `sio_d_in` is sampled on entry.
  - q3: SCL low.
- **START (4 q):** SDA=1/SCL=1, then SDA falls at q2 with SCL high, then SCL falls at q3.
- **STOP (4 q):** SDA=0/SCL low, then SCL rises at q1, then SDA rises at q2.
- **Byte framing:** each byte is 8 bits MSB first plus a 9th "don't-care" bit with `sio_d_oe`=0. The 9th bit's value is ignored; no NACK handling, per SCCB.
- **Write (3-phase):** START, DEV_ID, X, addr, X, wdata, X, STOP.
- **Read (2-phase write, then 2-phase read):**
  - Phase 1: START, DEV_ID, X, addr, X, STOP.
  - GAP: 4 quarters idle-high.
  - Phase 2: START, DEV_ID|1, X, 8 read bits (`oe`=0), NA bit (master drives 1), STOP.
- **Read completion:** `rdata` loads the shift register and `rdata_vld` pulses in the cycle the final STOP quarter completes.
- **FSM states:** IDLE, GRANT, START, BYTE, STOP, GAP.
  - IDLE → GRANT: `rdy`=1 for exactly one cycle on the transition.
  - GRANT: waits 2 cycles for a command. Timeout returns to IDLE, which re-pulses `rdy`.
  - Command in GRANT, or in IDLE: latch `addr`/`wdata`/type, then → START.
  - START → BYTE. BYTE loops over the bytes via `byte_cnt`, then → STOP.
  - STOP after read phase 1 → GAP → START.
  - Otherwise STOP → IDLE.
- **Simultaneous `wr_en`&`rd_en`:** write is performed and `rd_en` is dropped.
- **Commands while busy** (START..GAP) are ignored; `rdy` stays 0 throughout.
- **Reset mid-transaction:** immediate return to reset values next clk, with the bus released high. No STOP is generated; the sensor resynchronises on the next START.
- **Handshake rationale:** the upstream sequencer advances on every `rdy`-high cycle and issues its command one cycle later. `rdy` must therefore never be high two consecutive cycles, and must never be high while a command is in flight.

## Timing
- `rdy` pulse (t) → command at t+1 or t+2 → START q0 begins at command cycle +1.
- Write: 116 quarters (29 slots), i.e. 116·SCL_QTR clk.
- Read: 164 quarters (80 + 4 + 80).
- Idle `rdy` cadence with no command: one pulse every 3 clk cycles.
- Next `rdy` comes 1 clk after the transaction ends: IDLE, then GRANT.
- `rdata` and `rdata_vld` are registered; `rdata` holds until the next read.

## Test plan
- **Write:** `SCL_QTR`=2, `wr_en` with addr=0x12, wdata=0x04.
  - SDA bits at SCL rising edges: 0x42, X, 0x12, X, 0x04, X.
  - START and STOP are correct; duration 232 clk; `rdy` pulses 1 clk later.
- **Read:** `rd_en` addr=0x0A with a slave model returning 0x76.
  - Bus shows 0x42, 0x0A, STOP, GAP, START, 0x43; `oe`=0 during data; NA=1.
  - `rdata`=0x76 with a single `rdata_vld` pulse.
- **Config handshake:** drive with `ov7670_config`-style logic (wr at `rdy`+1, rd at the next `rdy`+1) over 3 entries.
  - Exactly 3 writes and 3 reads occur, in order, with no doubled transactions.
- **No command:** `rdy` pulses at cycles 1, 4, 7, …; `sio_c`/`sio_d` stay high.
- **Simultaneous `wr_en`+`rd_en`:** only the write occurs and `rdata_vld` never asserts.
- **Reset mid-byte:** `rst` asserted during a write's addr byte.
  - Next cycle: all outputs at reset values.
  - Next command completes correctly.
